// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the cache-to-memory block bus.
// Holds the arbiter state encoding, the grant encoding and the bus geometry
// constants used by mem_bus_arbiter.
package cpu_mem_pkg;

  localparam int BEATS_PER_BLOCK = 4;
  localparam int BLOCK_BITS      = 128;
  localparam int WORD_BITS       = 32;
  localparam int BLOCK_ADDR_BITS = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Which cache owns (or last owned) the memory bus.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit word memory between an instruction cache
// and a data cache that both move whole 128-bit blocks.
//
// Ports
//   CLK, RESET        clock, asynchronous active-high reset
//   I_READ/I_ADDR     instruction-cache block read request and block address
//   I_READ_DATA       fetched block (shared buffer)
//   I_BUSY_WAIT       stall to the instruction cache
//   D_READ/D_WRITE    data-cache block read / write-back request
//   D_ADDR            data-cache block address
//   D_WRITE_DATA      block to write back
//   D_READ_DATA       fetched block (shared buffer)
//   D_BUSY_WAIT       stall to the data cache
//   MEM_*             word-wide memory port, 4 beats per block
//
// A granted transfer always runs all four beats; the requester only sees the
// result in the single DONE cycle, when its busy-wait drops.
module mem_bus_arbiter
  import cpu_mem_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       I_READ,
  input  logic [BLOCK_ADDR_BITS-1:0] I_ADDR,
  output logic [BLOCK_BITS-1:0]      I_READ_DATA,
  output logic                       I_BUSY_WAIT,
  input  logic                       D_READ,
  input  logic                       D_WRITE,
  input  logic [BLOCK_ADDR_BITS-1:0] D_ADDR,
  input  logic [BLOCK_BITS-1:0]      D_WRITE_DATA,
  output logic [BLOCK_BITS-1:0]      D_READ_DATA,
  output logic                       D_BUSY_WAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [31:0]                MEM_ADDR,
  output logic [WORD_BITS-1:0]       MEM_WRITE_DATA,
  input  logic [WORD_BITS-1:0]       MEM_READ_DATA,
  input  logic                       MEM_BUSY_WAIT
);

  state_t                     state_q, state_d;
  gnt_t                       gnt_q, gnt_d;
  logic                       wr_q, wr_d;
  logic [1:0]                 beat_q, beat_d;
  logic [BLOCK_ADDR_BITS-1:0] addr_q, addr_d;
  logic [BLOCK_BITS-1:0]      buf_q, buf_d;

  logic i_req, d_req, in_xfer, in_done;
  gnt_t pick;
  logic [6:0] word_lsb;

  assign i_req    = I_READ;
  assign d_req    = D_READ | D_WRITE;
  assign in_xfer  = (state_q == ST_XFER);
  assign in_done  = (state_q == ST_DONE);
  assign word_lsb = {beat_q, 5'b00000};

  // On a tie the side that was not served last wins; gnt_q keeps the
  // last-served side after the transfer ends.
  always_comb begin
    if (i_req && d_req) begin
      pick = (gnt_q == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      pick = GNT_D;
    end else begin
      pick = GNT_I;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_d = ST_XFER;
          gnt_d   = pick;
          beat_d  = 2'd0;
          // A data request with both strobes high is a write-back.
          wr_d    = (pick == GNT_D) && D_WRITE;
          addr_d  = (pick == GNT_D) ? D_ADDR : I_ADDR;
        end
      end
      ST_XFER: begin
        if (!MEM_BUSY_WAIT) begin
          if (!wr_q) begin
            buf_d[word_lsb +: WORD_BITS] = MEM_READ_DATA;
          end
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'(BEATS_PER_BLOCK - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= GNT_I;
      wr_q    <= 1'b0;
      beat_q  <= 2'd0;
      addr_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  // Memory strobes exist only in XFER; being decoded from registered state,
  // they drop the moment RESET forces the state back to IDLE.
  assign MEM_READ       = in_xfer & ~wr_q;
  assign MEM_WRITE      = in_xfer & wr_q;
  assign MEM_ADDR       = in_xfer ? {addr_q, beat_q, 2'b00} : 32'd0;
  assign MEM_WRITE_DATA = (in_xfer && wr_q) ? D_WRITE_DATA[word_lsb +: WORD_BITS]
                                            : '0;

  assign I_READ_DATA = buf_q;
  assign D_READ_DATA = buf_q;

  assign I_BUSY_WAIT = i_req & ~(in_done & (gnt_q == GNT_I));
  assign D_BUSY_WAIT = d_req & ~(in_done & (gnt_q == GNT_D));

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The port list SHALL have one clock and an asynchronous, active-high reset, with clock and reset listed first:
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET  in  1  asynchronous active-high reset.
REQ-002 Instruction-cache side ports SHALL be:
- I_READ  in  1  block read request.
- I_ADDR  in  28  block address, byte address [31:4].
- I_READ_DATA  out  128  fetched block.
- I_BUSY_WAIT  out  1  stall to the instruction cache.
REQ-003 Data-cache side ports SHALL be:
- D_READ  in  1  block read request.
- D_WRITE  in  1  block write-back request.
- D_ADDR  in  28  block address.
- D_WRITE_DATA  in  128  block to write.
- D_READ_DATA  out  128  fetched block.
- D_BUSY_WAIT  out  1  stall to the data cache.
REQ-004 Memory side ports SHALL be:
- MEM_READ  out  1  word read strobe.
- MEM_WRITE  out  1  word write strobe.
- MEM_ADDR  out  32  word byte address.
- MEM_WRITE_DATA  out  32  write word.
- MEM_READ_DATA  in  32  read word.
- MEM_BUSY_WAIT  in  1  memory not ready.

Function
REQ-005 The FSM SHALL have the states IDLE, XFER and DONE, plus a registered grant flag GNT with values I or D.
REQ-006 In IDLE, the block SHALL sample the requests at the rising edge:
- Only one side requesting: grant it and go to XFER with beat=0.
- Both sides requesting: grant the side not served last (round-robin).
- No request: stay in IDLE.
REQ-007 A data request SHALL be D_READ|D_WRITE; if both are high, the transfer SHALL be a write.
REQ-008 In XFER, the strobes SHALL be driven as follows:
- MEM_READ or MEM_WRITE is high, per the granted operation.
- MEM_ADDR = {granted block address, beat[1:0], 2'b00}.
- MEM_WRITE_DATA = D_WRITE_DATA[32*beat+31 : 32*beat].
REQ-009 A beat SHALL be accepted on a rising edge in XFER with MEM_BUSY_WAIT low:
- On a read, MEM_READ_DATA is captured into buffer bits [32*beat+31 : 32*beat].
- beat increments by 1.
- On acceptance of beat 3, the FSM goes to DONE.
REQ-010 While MEM_BUSY_WAIT is high, the state, beat, address and strobes SHALL hold unchanged.
REQ-011 DONE SHALL last exactly one cycle, then return to IDLE, recording the last-served side as GNT.
REQ-012 I_READ_DATA and D_READ_DATA SHALL both be driven from the single 128-bit buffer; contents are valid in DONE and held until the next read transfer.
REQ-013 The busy-wait outputs SHALL be combinational:
- I_BUSY_WAIT = I_READ & ~(DONE & GNT==I).
- D_BUSY_WAIT = (D_READ|D_WRITE) & ~(DONE & GNT==D).
REQ-014 Requesters SHALL hold their request until busy-wait falls. A request still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-015 A request withdrawn mid-XFER SHALL NOT abort the transfer: all 4 beats complete and the result is ignored.
REQ-016 Latency with MEM_BUSY_WAIT stuck low SHALL be 6 cycles: request raised in cycle 0, accepted at edge 1, beats at edges 2-5, busy-wait low in cycle 5.
REQ-017 MEM_READ and MEM_WRITE SHALL never be high together; both SHALL be low outside XFER.

Reset
REQ-018 RESET high SHALL immediately apply the following, including mid-transfer, which aborts it with no further strobes:
- State = IDLE, beat = 0, GNT = I, so D wins the first tie.
- Buffer = 0, MEM_ADDR = 0, MEM_WRITE_DATA = 0, MEM_READ = 0, MEM_WRITE = 0.
REQ-019 During reset, the busy-wait outputs SHALL still follow REQ-013.

Structure
REQ-020 The shared package cpu_mem_pkg SHALL hold:
- the state enum;
- constants BEATS_PER_BLOCK=4, BLOCK_BITS=128, WORD_BITS=32, BLOCK_ADDR_BITS=28.
REQ-021 The block SHALL be flat, with no sub-module. The beat counter and buffer SHALL stay inline.

Verification
REQ-022 Scenario: I_READ, I_ADDR=0x0000010, zero-wait memory, MEM_READ_DATA = 0x11,0x22,0x33,0x44 -> MEM_ADDR 0x100,0x104,0x108,0x10C; I_READ_DATA=0x00000044_00000033_00000022_00000011; I_BUSY_WAIT low in cycle 5 only.
REQ-023 Scenario: D_WRITE, D_ADDR=0x0000020, D_WRITE_DATA=0xDDDD_CCCC_BBBB_AAAA (one value per word, word 0 = 0xAAAA), MEM_BUSY_WAIT high 2 cycles per beat -> 4 write beats in order 0xAAAA..0xDDDD, addresses 0x200-0x20C; D_BUSY_WAIT low in cycle 13.
REQ-024 Scenario: I_READ and D_READ raised the same cycle after reset -> D served first, then I; the second busy-wait falls 6 cycles after the first.
REQ-025 Scenario: D_READ and D_WRITE both high -> write beats only, MEM_READ never high.
REQ-026 Scenario: RESET asserted after beat 1 of an I read -> strobes low asynchronously; after release, the pending I_READ restarts from beat 0 at the original address.
